// File: rtl/processor_host_arbiter.sv
// Run controller and data-RAM arbiter: the processor owns the RAM port while running,
// the host gets single-word access once the processor parks on a wait.
module processor_host_arbiter #(
    parameter int unsigned ADDR_SIZE = 18,
    parameter int unsigned WORD_SIZE = 18
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cpu_write_enable,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_data_in,
    output logic [WORD_SIZE-1:0] cpu_data_out,
    input  logic                 cpu_waiting,
    output logic                 cpu_continue,
    output logic                 mem_write_enable,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_in,
    input  logic [WORD_SIZE-1:0] mem_out,
    input  logic                 host_req,
    input  logic                 host_write,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [WORD_SIZE-1:0] host_wdata,
    output logic                 host_ack,
    output logic [WORD_SIZE-1:0] host_rdata,
    input  logic                 host_run,
    output logic                 host_stopped
);

    typedef enum logic [2:0] {
        CPU_OWN,
        DRAIN,
        HOST_IDLE,
        ACCESS,
        CAPTURE,
        RESUME
    } state_t;

    state_t                state_q, state_d;
    logic                  run_q, run_d;
    logic                  lat_write_q, lat_write_d;
    logic [ADDR_SIZE-1:0]  lat_addr_q, lat_addr_d;
    logic [WORD_SIZE-1:0]  lat_wdata_q, lat_wdata_d;
    logic                  host_ack_q, host_ack_d;
    logic [WORD_SIZE-1:0]  host_rdata_q, host_rdata_d;
    logic                  cpu_continue_q, cpu_continue_d;
    logic                  host_stopped_q, host_stopped_d;

    // Read data returns straight to the processor; it ignores it while parked.
    assign cpu_data_out = mem_out;
    assign host_ack     = host_ack_q;
    assign host_rdata   = host_rdata_q;
    assign cpu_continue = cpu_continue_q;
    assign host_stopped = host_stopped_q;

    // Next-state, RAM port mux and registered-output next values.
    always_comb begin
        state_d          = state_q;
        run_d            = run_q;
        lat_write_d      = lat_write_q;
        lat_addr_d       = lat_addr_q;
        lat_wdata_d      = lat_wdata_q;
        host_ack_d       = 1'b0;
        host_rdata_d     = host_rdata_q;
        host_stopped_d   = (state_q == HOST_IDLE) || (state_q == ACCESS) || (state_q == CAPTURE);
        mem_write_enable = cpu_write_enable;
        mem_addr         = cpu_addr;
        mem_in           = cpu_data_in;

        case (state_q)
            CPU_OWN: begin
                if (cpu_waiting) state_d = DRAIN;
            end
            DRAIN: begin
                state_d = cpu_waiting ? HOST_IDLE : CPU_OWN;
            end
            HOST_IDLE: begin
                mem_write_enable = 1'b0;
                // A run request beats a simultaneous transaction request.
                if (run_q || host_run) begin
                    state_d = RESUME;
                end else if (host_req && !host_ack_q) begin
                    lat_write_d = host_write;
                    lat_addr_d  = host_addr;
                    lat_wdata_d = host_wdata;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                mem_write_enable = lat_write_q;
                mem_addr         = lat_addr_q;
                mem_in           = lat_wdata_q;
                if (host_run) run_d = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                mem_write_enable = 1'b0;
                mem_addr         = lat_addr_q;
                mem_in           = lat_wdata_q;
                if (!lat_write_q) host_rdata_d = mem_out;
                host_ack_d = 1'b1;
                if (host_run) run_d = 1'b1;
                state_d = HOST_IDLE;
            end
            RESUME: begin
                run_d   = 1'b0;
                state_d = CPU_OWN;
            end
            default: begin
                state_d = CPU_OWN;
            end
        endcase

        cpu_continue_d = (state_d == RESUME);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= CPU_OWN;
            run_q          <= 1'b0;
            lat_write_q    <= 1'b0;
            lat_addr_q     <= '0;
            lat_wdata_q    <= '0;
            host_ack_q     <= 1'b0;
            host_rdata_q   <= '0;
            cpu_continue_q <= 1'b0;
            host_stopped_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            run_q          <= run_d;
            lat_write_q    <= lat_write_d;
            lat_addr_q     <= lat_addr_d;
            lat_wdata_q    <= lat_wdata_d;
            host_ack_q     <= host_ack_d;
            host_rdata_q   <= host_rdata_d;
            cpu_continue_q <= cpu_continue_d;
            host_stopped_q <= host_stopped_d;
        end
    end

endmodule

// File: tb/tb_processor_host_arbiter.sv
// Self-checking bench for processor_host_arbiter: RAM model, host transaction scoreboard.
module tb_processor_host_arbiter;

    localparam int unsigned AW = 18;
    localparam int unsigned WW = 18;

    logic          clock;
    logic          reset;
    logic          cpu_write_enable;
    logic [AW-1:0] cpu_addr;
    logic [WW-1:0] cpu_data_in;
    logic [WW-1:0] cpu_data_out;
    logic          cpu_waiting;
    logic          cpu_continue;
    logic          mem_write_enable;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_in;
    logic [WW-1:0] mem_out;
    logic          host_req;
    logic          host_write;
    logic [AW-1:0] host_addr;
    logic [WW-1:0] host_wdata;
    logic          host_ack;
    logic [WW-1:0] host_rdata;
    logic          host_run;
    logic          host_stopped;

    processor_host_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(WW)) dut (
        .clock(clock), .reset(reset),
        .cpu_write_enable(cpu_write_enable), .cpu_addr(cpu_addr),
        .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
        .cpu_waiting(cpu_waiting), .cpu_continue(cpu_continue),
        .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
        .mem_in(mem_in), .mem_out(mem_out),
        .host_req(host_req), .host_write(host_write), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .host_run(host_run), .host_stopped(host_stopped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM: read data valid the cycle after the address.
    logic [WW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (mem_write_enable) ram[mem_addr] <= mem_in;
        mem_out <= ram[mem_addr];
    end

    typedef struct packed {
        logic          rd;
        logic [WW-1:0] data;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    logic [WW-1:0] shadow [logic [AW-1:0]];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            ack_count  = 0;
    int            cont_count = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Ack monitor: pops the scoreboard and checks read data on every ack.
    always @(negedge clock) begin
        if (cpu_continue) cont_count++;
        if (host_ack) begin
            ack_count++;
            if (sb_q.size() == 0) begin
                chk("spurious_ack", 32'(1), 32'(0));
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.rd) chk("host_rdata", 32'(host_rdata), 32'(mon_e.data));
            end
        end
    end

    task automatic issue_req(input logic wr, input logic [AW-1:0] a, input logic [WW-1:0] d,
                             input logic push);
        @(posedge clock); #1;
        host_req   = 1'b1;
        host_write = wr;
        host_addr  = a;
        host_wdata = d;
        if (push) begin
            if (wr) begin
                shadow[a] = d;
                sb_q.push_back({1'b0, d});
            end else begin
                sb_q.push_back({1'b1, shadow.exists(a) ? shadow[a] : WW'(0)});
            end
        end
    endtask

    // Edges from the request's sampling edge to the ack cycle; drops the request on ack.
    task automatic wait_ack(input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clock);
            if (host_ack) begin
                lat = k - 1;
                break;
            end
        end
        host_req = 1'b0;
        if (lat < 0) chk("ack_timeout", 32'(0), 32'(1));
    endtask

    task automatic host_txn(input logic wr, input logic [AW-1:0] a, input logic [WW-1:0] d,
                            output int lat);
        issue_req(wr, a, d, 1'b1);
        wait_ack(20, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int lat;
    int acks0, conts0;

    initial begin
        reset = 1'b1;
        cpu_write_enable = 1'b0; cpu_addr = '0; cpu_data_in = '0; cpu_waiting = 1'b0;
        host_req = 1'b0; host_write = 1'b0; host_addr = '0; host_wdata = '0; host_run = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_ack", 32'(host_ack), 32'(0));
        chk("rst_rdata", 32'(host_rdata), 32'(0));
        chk("rst_stopped", 32'(host_stopped), 32'(0));
        chk("rst_continue", 32'(cpu_continue), 32'(0));
        @(posedge clock); #1 reset = 1'b0;

        // CPU pass-through
        @(posedge clock); #1;
        cpu_write_enable = 1'b1; cpu_addr = 18'h10; cpu_data_in = 18'h2A;
        @(negedge clock);
        chk("pt_we", 32'(mem_write_enable), 32'(1));
        chk("pt_addr", 32'(mem_addr), 32'h10);
        chk("pt_in", 32'(mem_in), 32'h2A);
        chk("pt_stopped", 32'(host_stopped), 32'(0));
        cpu_write_enable = 1'b0;

        // One-cycle wait pulse returns to the processor
        @(posedge clock); #1 cpu_waiting = 1'b1;
        @(posedge clock); #1 cpu_waiting = 1'b0;
        repeat (4) @(negedge clock);
        chk("pulse_stopped", 32'(host_stopped), 32'(0));
        cpu_write_enable = 1'b1; cpu_addr = 18'h11; cpu_data_in = 18'h5;
        #1;
        chk("pulse_pt_we", 32'(mem_write_enable), 32'(1));
        chk("pulse_pt_addr", 32'(mem_addr), 32'h11);
        @(posedge clock); #1 cpu_write_enable = 1'b0;

        // Request pending in CPU_OWN, serviced after the stop
        issue_req(1'b1, 18'h55, 18'h12345, 1'b1);
        repeat (4) @(negedge clock);
        chk("pending_no_ack", 32'(ack_count), 32'(0));
        @(posedge clock); #1 cpu_waiting = 1'b1;
        wait_ack(20, lat);
        chk("pending_latency", 32'(lat), 32'(5));

        // Host write then read at the top of the address/data range
        host_txn(1'b1, 18'h3FFFF, 18'h3FFFF, lat);
        chk("wr_latency", 32'(lat), 32'(3));
        host_txn(1'b0, 18'h3FFFF, '0, lat);
        chk("rd_latency", 32'(lat), 32'(3));
        host_txn(1'b0, 18'h55, '0, lat);
        chk("rd2_latency", 32'(lat), 32'(3));
        chk("stopped_hi", 32'(host_stopped), 32'(1));

        // Resume requested during ACCESS: ack first, then one continue pulse
        issue_req(1'b0, 18'h3FFFF, '0, 1'b1);
        @(negedge clock);
        @(negedge clock); host_run = 1'b1;
        @(negedge clock); host_run = 1'b0;
        chk("cpu_data_out", 32'(cpu_data_out), 32'h3FFFF);
        @(negedge clock);
        chk("res_ack", 32'(host_ack), 32'(1));
        chk("res_cont_early", 32'(cpu_continue), 32'(0));
        host_req = 1'b0;
        cpu_waiting = 1'b0; cpu_write_enable = 1'b1; cpu_addr = 18'h21; cpu_data_in = 18'h7;
        @(negedge clock);
        chk("res_cont", 32'(cpu_continue), 32'(1));
        chk("res_mem_we", 32'(mem_write_enable), 32'(1));
        chk("res_mem_addr", 32'(mem_addr), 32'h21);
        chk("res_mem_in", 32'(mem_in), 32'h7);
        @(negedge clock);
        chk("res_cont_pulse", 32'(cpu_continue), 32'(0));
        chk("res_cont_count", 32'(cont_count), 32'(1));
        cpu_write_enable = 1'b0;

        // Stop latency
        @(posedge clock); #1 cpu_waiting = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("stop_lat_e0", 32'(host_stopped), 32'(0));
        @(negedge clock);
        @(negedge clock);
        chk("stop_lat_e2", 32'(host_stopped), 32'(1));

        // Simultaneous run and request: run wins, request waits for the next stop
        acks0 = ack_count; conts0 = cont_count;
        issue_req(1'b0, 18'h55, '0, 1'b1);
        host_run = 1'b1;
        @(posedge clock); #1 host_run = 1'b0; cpu_waiting = 1'b0;
        repeat (4) @(negedge clock);
        chk("sim_no_ack", 32'(ack_count), 32'(acks0));
        chk("sim_cont", 32'(cont_count), 32'(conts0 + 1));

        // host_run while the processor runs is dropped
        @(posedge clock); #1 host_run = 1'b1;
        @(posedge clock); #1 host_run = 1'b0;
        repeat (3) @(negedge clock);
        chk("cpu_run_drop", 32'(cont_count), 32'(conts0 + 1));
        @(posedge clock); #1 cpu_waiting = 1'b1;
        wait_ack(20, lat);
        chk("sim_req_latency", 32'(lat), 32'(5));
        repeat (3) @(negedge clock);
        chk("cpu_run_drop2", 32'(cont_count), 32'(conts0 + 1));
        chk("stopped_again", 32'(host_stopped), 32'(1));

        // Reset during ACCESS aborts the transaction
        acks0 = ack_count;
        issue_req(1'b1, 18'h77, 18'h1ABCD, 1'b0);
        @(negedge clock);
        @(negedge clock);
        chk("abort_access_we", 32'(mem_write_enable), 32'(1));
        chk("abort_access_addr", 32'(mem_addr), 32'h77);
        reset = 1'b1; host_req = 1'b0; cpu_waiting = 1'b0;
        @(negedge clock);
        chk("abort_we", 32'(mem_write_enable), 32'(0));
        chk("abort_rdata", 32'(host_rdata), 32'(0));
        chk("abort_stopped", 32'(host_stopped), 32'(0));
        chk("abort_ack", 32'(host_ack), 32'(0));
        @(posedge clock); #1 reset = 1'b0;
        repeat (5) @(negedge clock);
        chk("abort_no_ack", 32'(ack_count), 32'(acks0));
        chk("abort_cpu_own", 32'(host_stopped), 32'(0));
        chk("sb_empty", 32'(sb_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
